// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values and change-dispenser state encoding.
package vm_pkg;

    localparam int unsigned COIN1_VAL = 1;
    localparam int unsigned COIN2_VAL = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT1,
        ST_WAIT2,
        ST_GAP,
        ST_FAULT
    } disp_state_t;

endpackage

// File: rtl/vm_cycle_timer.sv
// Load/enable up-counter with a terminal-count flag; serves both the ack timeout and the inter-coin gap.
module vm_cycle_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/vm_change_dispenser.sv
// Turns change/refund requests into a greedy sequence of value-2 / value-1 coin ejections,
// each handshaken with the hopper exit sensor; stalled or empty hoppers raise a fault.
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned AMT_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdt,
    input  logic [2:0]       cng,
    input  logic [2:0]       rtn,
    input  logic             hop1_empty,
    input  logic             hop2_empty,
    input  logic             hop1_ack,
    input  logic             hop2_ack,
    input  logic             fault_clr,
    output logic             hop1_eject,
    output logic             hop2_eject,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic             ovf
);

    localparam int unsigned TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int unsigned SUM_W   = AMT_W + 4;
    localparam logic [SUM_W-1:0] AMT_MAX = {{4{1'b0}}, {AMT_W{1'b1}}};

    disp_state_t      r_state;
    disp_state_t      w_next;
    logic             r_pdt_q;
    logic [2:0]       r_rtn_q;
    logic [AMT_W-1:0] r_remaining;
    logic             r_ovf;
    logic             r_done;

    logic             w_req_c;
    logic             w_req_r;
    logic [1:0]       w_dec;
    logic [SUM_W-1:0] w_sum;
    logic             w_sat;
    logic [AMT_W-1:0] w_rem_next;
    logic             w_tmr_tc;
    logic [TMR_W-1:0] w_tmr_limit;

    assign w_req_c = pdt & ~r_pdt_q & (cng != 3'd0);
    assign w_req_r = (rtn != 3'd0) & (r_rtn_q == 3'd0);

    always_comb begin
        w_dec = '0;
        if (r_state == ST_WAIT1 && hop1_ack) w_dec = 2'(COIN1_VAL);
        if (r_state == ST_WAIT2 && hop2_ack) w_dec = 2'(COIN2_VAL);
    end

    // Decrement is applied before the add; the wide sum cannot underflow because WAITn is only
    // entered with at least n units owed.
    assign w_sum = SUM_W'(r_remaining) - SUM_W'(w_dec)
                 + (w_req_c ? SUM_W'(cng) : '0)
                 + (w_req_r ? SUM_W'(rtn) : '0);
    assign w_sat      = (w_sum > AMT_MAX);
    assign w_rem_next = w_sat ? '1 : w_sum[AMT_W-1:0];

    assign w_tmr_limit = (r_state == ST_GAP) ? TMR_W'(GAP_CYC - 1) : TMR_W'(TIMEOUT_CYC - 1);

    vm_cycle_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_next != r_state),
        .i_en    (r_state inside {ST_WAIT1, ST_WAIT2, ST_GAP}),
        .i_limit (w_tmr_limit),
        .o_tc    (w_tmr_tc)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            // Looks at the post-request amount so SELECT is reached on the request edge itself.
            ST_IDLE:   if (w_rem_next != '0) w_next = ST_SELECT;
            ST_SELECT: begin
                if (r_remaining == '0)                                      w_next = ST_IDLE;
                else if (r_remaining >= AMT_W'(COIN2_VAL) && !hop2_empty)   w_next = ST_WAIT2;
                else if (!hop1_empty)                                       w_next = ST_WAIT1;
                else                                                        w_next = ST_FAULT;
            end
            ST_WAIT1: begin
                if (hop1_ack)      w_next = ST_GAP;
                else if (w_tmr_tc) w_next = ST_FAULT;
            end
            ST_WAIT2: begin
                if (hop2_ack)      w_next = ST_GAP;
                else if (w_tmr_tc) w_next = ST_FAULT;
            end
            ST_GAP:    if (w_tmr_tc) w_next = ST_SELECT;
            ST_FAULT:  if (fault_clr) w_next = ST_SELECT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pdt_q     <= 1'b0;
            r_rtn_q     <= '0;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pdt_q     <= pdt;
            r_rtn_q     <= rtn;
            r_remaining <= w_rem_next;
            r_ovf       <= r_ovf | w_sat;
            r_done      <= (r_state == ST_SELECT) && (r_remaining == '0);
        end
    end

    assign hop1_eject = (r_state == ST_WAIT1);
    assign hop2_eject = (r_state == ST_WAIT2);
    assign busy       = (r_state != ST_IDLE);
    assign fault      = (r_state == ST_FAULT);
    assign done       = r_done;
    assign remaining  = r_remaining;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser with hand-computed expectations.
module tb_vm_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pdt = 1'b0;
    logic [2:0] cng = '0;
    logic [2:0] rtn = '0;
    logic       hop1_empty = 1'b0;
    logic       hop2_empty = 1'b0;
    logic       hop1_ack = 1'b0;
    logic       hop2_ack = 1'b0;
    logic       fault_clr = 1'b0;
    logic       hop1_eject, hop2_eject, busy, done, fault, ovf;
    logic [3:0] remaining;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned done_cnt = 0;
    int unsigned hop1_cyc = 0;

    vm_change_dispenser #(
        .AMT_W       (4),
        .TIMEOUT_CYC (16),
        .GAP_CYC     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pdt        (pdt),
        .cng        (cng),
        .rtn        (rtn),
        .hop1_empty (hop1_empty),
        .hop2_empty (hop2_empty),
        .hop1_ack   (hop1_ack),
        .hop2_ack   (hop2_ack),
        .fault_clr  (fault_clr),
        .hop1_eject (hop1_eject),
        .hop2_eject (hop2_eject),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_eject(input bit two, input string tag);
        int n = 0;
        while (!(two ? hop2_eject : hop1_eject) && n < 60) begin
            tick();
            n++;
        end
        chk(tag, two ? hop2_eject : hop1_eject, 1);
    endtask

    task automatic ack_coin(input bit two);
        tick();
        tick();
        if (two) hop2_ack = 1'b1; else hop1_ack = 1'b1;
        tick();
        hop1_ack = 1'b0;
        hop2_ack = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        tick();
        chk(tag, busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) chk("eject_excl", hop1_eject & hop2_eject, 0);
        if (done) done_cnt++;
        if (hop1_eject) hop1_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_rem", remaining, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ej", {hop1_eject, hop2_eject}, 0);
        chk("rst_flags", {done, fault, ovf}, 0);
        rst = 1'b0;
        tick();

        // 1: cng=3, greedy value-2 then value-1
        done_cnt = 0;
        pdt = 1'b1; cng = 3'd3;
        tick();
        chk("t1_rem_n", remaining, 3);
        chk("t1_busy_n", busy, 1);
        chk("t1_ej_n", hop2_eject, 0);
        pdt = 1'b0;
        tick();
        chk("t1_ej2_n1", hop2_eject, 1);
        ack_coin(1'b1);
        chk("t1_rem_a", remaining, 1);
        chk("t1_ej2_off", hop2_eject, 0);
        wait_eject(1'b0, "t1_ej1");
        ack_coin(1'b0);
        chk("t1_rem_b", remaining, 0);
        wait_idle("t1_idle");
        chk("t1_done", done_cnt, 1);
        chk("t1_fault", fault, 0);

        // 2: rtn 0->5 with value-2 hopper empty
        done_cnt = 0;
        hop2_empty = 1'b1;
        rtn = 3'd5;
        tick();
        chk("t2_rem0", remaining, 5);
        for (int i = 0; i < 5; i++) begin
            wait_eject(1'b0, "t2_ej1");
            ack_coin(1'b0);
            chk("t2_rem", remaining, 32'(4 - i));
        end
        wait_idle("t2_idle");
        chk("t2_done", done_cnt, 1);
        chk("t2_fault", fault, 0);
        rtn = 3'd0;
        hop2_empty = 1'b0;
        tick();

        // 3: single coin, no ack -> timeout fault, then recovery
        pdt = 1'b1; cng = 3'd1;
        hop1_cyc = 0;
        tick();
        pdt = 1'b0;
        for (int n = 0; n < 60 && !fault; n++) tick();
        chk("t3_fault", fault, 1);
        chk("t3_ej1_cyc", hop1_cyc, 16);
        chk("t3_rem", remaining, 1);
        done_cnt = 0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t3_clr", fault, 0);
        wait_eject(1'b0, "t3_ej1");
        ack_coin(1'b0);
        chk("t3_rem0", remaining, 0);
        wait_idle("t3_idle");
        chk("t3_done", done_cnt, 1);

        // 4: refund request lands during WAIT2
        done_cnt = 0;
        pdt = 1'b1; cng = 3'd3;
        tick();
        pdt = 1'b0;
        wait_eject(1'b1, "t4_ej2a");
        rtn = 3'd4;
        tick();
        chk("t4_rem7", remaining, 7);
        tick();
        hop2_ack = 1'b1;
        tick();
        hop2_ack = 1'b0;
        chk("t4_rem5", remaining, 5);
        wait_eject(1'b1, "t4_ej2b");
        ack_coin(1'b1);
        chk("t4_rem3", remaining, 3);
        wait_eject(1'b1, "t4_ej2c");
        ack_coin(1'b1);
        chk("t4_rem1", remaining, 1);
        wait_eject(1'b0, "t4_ej1");
        ack_coin(1'b0);
        chk("t4_rem0", remaining, 0);
        wait_idle("t4_idle");
        chk("t4_done", done_cnt, 1);
        rtn = 3'd0;
        tick();

        // 5: saturation with both hoppers empty
        hop1_empty = 1'b1; hop2_empty = 1'b1;
        pdt = 1'b1; cng = 3'd7; rtn = 3'd7;
        tick();
        chk("t5_rem14", remaining, 14);
        chk("t5_ovf0", ovf, 0);
        pdt = 1'b0;
        tick();
        tick();
        chk("t5_fault", fault, 1);
        chk("t5_ej_off", {hop1_eject, hop2_eject}, 0);
        pdt = 1'b1; cng = 3'd3;
        tick();
        chk("t5_rem15", remaining, 15);
        chk("t5_ovf1", ovf, 1);
        pdt = 1'b0;
        tick(); tick(); tick();
        chk("t5_ovf_sticky", ovf, 1);
        chk("t5_rem_hold", remaining, 15);

        // 6: reset during WAIT2
        hop1_empty = 1'b0; hop2_empty = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        wait_eject(1'b1, "t6_ej2");
        rst = 1'b1;
        tick();
        chk("t6_ej", {hop1_eject, hop2_eject}, 0);
        chk("t6_rem", remaining, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf", ovf, 0);
        rst = 1'b0;
        rtn = 3'd0;
        tick();

        // pdt rise with zero change is not a request
        pdt = 1'b1; cng = 3'd0;
        tick();
        tick();
        chk("zero_cng_busy", busy, 0);
        chk("zero_cng_rem", remaining, 0);
        pdt = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
